// File: rtl/bcd_counter_ndigit.sv
// N-digit BCD up/down counter with programmable wrap limit, sync clear/load,
// count enable and combinational cascade carry for chaining instances.
module bcd_counter_ndigit #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic [4*DIGITS-1:0]   limit,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  co,
  output logic                  wrap
);

  logic [4*DIGITS-1:0] eff_limit;
  logic [4*DIGITS-1:0] load_sat;
  logic [4*DIGITS-1:0] count_inc;
  logic [4*DIGITS-1:0] count_dec;
  logic                carry;
  logic                borrow;
  logic                at_top;
  logic                at_zero;

  function automatic logic [3:0] sat9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  always_comb begin
    eff_limit = '0;
    load_sat  = '0;
    count_inc = count;
    count_dec = count;
    carry     = 1'b1;
    borrow    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      eff_limit[4*i +: 4] = sat9(limit[4*i +: 4]);
      load_sat[4*i +: 4]  = sat9(load_val[4*i +: 4]);
      if (carry) begin
        if (count[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (count[4*i +: 4] == 4'd0) begin
          count_dec[4*i +: 4] = 4'd9;
        end else begin
          count_dec[4*i +: 4] = count[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  // With every nibble held to 0..9, a plain binary compare is a BCD magnitude compare.
  assign at_top  = (count >= eff_limit);
  assign at_zero = (count == '0);
  assign tc      = up_dn ? at_top : at_zero;
  assign co      = tc & en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clr) begin
        count <= '0;
      end else if (load) begin
        count <= load_sat;
      end else if (en) begin
        if (up_dn) begin
          if (at_top) begin
            count <= '0;
            wrap  <= 1'b1;
          end else begin
            count <= count_inc;
          end
        end else begin
          if (at_zero) begin
            count <= eff_limit;
            wrap  <= 1'b1;
          end else begin
            count <= count_dec;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// Self-checking bench: directed table, hand sequences, random stimulus against
// an integer-arithmetic reference model, and a two-instance cascade.
module tb_bcd_counter_ndigit;

  logic       clk = 1'b0;
  logic       reset, clr, load, en, up_dn;
  logic [7:0] load_val, limit, count;
  logic       tc, co, wrap;

  logic       reset_c, en_c;
  logic [3:0] count_lo, count_hi;
  logic       tc_lo, co_lo, wrap_lo, tc_hi, co_hi, wrap_hi;

  int n_cmp = 0;
  int n_bad = 0;
  int m_val = 0;
  bit m_wrap = 1'b0;

  always #5 clk = ~clk;

  bcd_counter_ndigit #(.DIGITS(2)) dut (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up_dn(up_dn), .limit(limit), .count(count), .tc(tc), .co(co), .wrap(wrap)
  );

  bcd_counter_ndigit #(.DIGITS(1)) u_lo (
    .clk(clk), .reset(reset_c), .clr(1'b0), .load(1'b0), .load_val(4'h0),
    .en(en_c), .up_dn(1'b1), .limit(4'h9), .count(count_lo), .tc(tc_lo), .co(co_lo), .wrap(wrap_lo)
  );

  bcd_counter_ndigit #(.DIGITS(1)) u_hi (
    .clk(clk), .reset(reset_c), .clr(1'b0), .load(1'b0), .load_val(4'h0),
    .en(co_lo), .up_dn(1'b1), .limit(4'h9), .count(count_hi), .tc(tc_hi), .co(co_hi), .wrap(wrap_hi)
  );

  typedef struct {
    logic       clr;
    logic       load;
    logic [7:0] lv;
    logic       en;
    logic       up;
    logic [7:0] lim;
    logic [7:0] exp_count;
    logic       exp_wrap;
    logic       exp_tc;
  } vec_t;

  vec_t tbl[17];

  function automatic int bcd2int(input logic [7:0] b);
    int hi = (b[7:4] > 4'd9) ? 9 : int'(b[7:4]);
    int lo = (b[3:0] > 4'd9) ? 9 : int'(b[3:0]);
    return hi * 10 + lo;
  endfunction

  function automatic logic [7:0] int2bcd(input int v);
    logic [3:0] hi = 4'((v / 10) % 10);
    logic [3:0] lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic c, input logic l, input logic [7:0] lv,
                      input logic e, input logic u, input logic [7:0] lim);
    int lim_i;
    clr = c; load = l; load_val = lv; en = e; up_dn = u; limit = lim;
    lim_i  = bcd2int(lim);
    m_wrap = 1'b0;
    if (c) m_val = 0;
    else if (l) m_val = bcd2int(lv);
    else if (e) begin
      if (u) begin
        if (m_val >= lim_i) begin m_val = 0; m_wrap = 1'b1; end
        else m_val = m_val + 1;
      end else begin
        if (m_val == 0) begin m_val = lim_i; m_wrap = 1'b1; end
        else m_val = m_val - 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    logic mtc;
    mtc = up_dn ? (m_val >= bcd2int(limit)) : (m_val == 0);
    chk({tag, "_count"}, 32'(count), 32'(int2bcd(m_val)));
    chk({tag, "_wrap"},  32'(wrap),  32'(m_wrap));
    chk({tag, "_tc"},    32'(tc),    32'(mtc));
    chk({tag, "_co"},    32'(co),    32'(mtc & en));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; clr = 1'b0; load = 1'b0; en = 1'b0; up_dn = 1'b0;
    load_val = 8'h00; limit = 8'h99;
    #2;
    chk("reset_count", 32'(count), 32'h0);
    chk("reset_wrap",  32'(wrap),  32'h0);
    chk("reset_tc",    32'(tc),    32'h1);
    chk("reset_co",    32'(co),    32'h0);
    @(negedge clk);
    reset = 1'b0;
    m_val = 0;
    m_wrap = 1'b0;
  endtask

  initial begin
    reset = 1'b0; clr = 1'b0; load = 1'b0; en = 1'b0; up_dn = 1'b0;
    load_val = 8'h00; limit = 8'h99;
    reset_c = 1'b1; en_c = 1'b0;

    //            clr  load lv     en   up   lim    count  wrap tc
    tbl[0]  = '{1'b0, 1'b1, 8'h7A, 1'b1, 1'b1, 8'h99, 8'h79, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 8'h55, 1'b1, 1'b1, 8'h99, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 8'h45, 1'b0, 1'b1, 8'h99, 8'h45, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h30, 8'h00, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 8'h45, 1'b0, 1'b1, 8'h30, 8'h45, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h30, 8'h44, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 8'h23, 8'h10, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h23, 8'h09, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h23, 8'h00, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h23, 8'h23, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h23, 8'h23, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 8'h28, 1'b0, 1'b1, 8'h2F, 8'h28, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h2F, 8'h29, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h2F, 8'h00, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};

    do_reset();

    // Full 0..99 up count
    for (int i = 1; i <= 99; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h99);
      chk("up99_count", 32'(count), 32'(int2bcd(i)));
      chk("up99_tc",    32'(tc),    32'(i == 99));
    end
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h99);
    chk("up99_wrap_count", 32'(count), 32'h00);
    chk("up99_wrap_pulse", 32'(wrap),  32'h1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h99);
    chk("up99_after_count", 32'(count), 32'h01);
    chk("up99_after_wrap",  32'(wrap),  32'h0);

    // Digit ripple and wrap at 59
    step(1'b0, 1'b1, 8'h08, 1'b0, 1'b1, 8'h59);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h59);
    chk("r59_09", 32'(count), 32'h09);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h59);
    chk("r59_10", 32'(count), 32'h10);
    chk("r59_tc10", 32'(tc), 32'h0);
    step(1'b0, 1'b1, 8'h58, 1'b0, 1'b1, 8'h59);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h59);
    chk("r59_59", 32'(count), 32'h59);
    chk("r59_tc59", 32'(tc), 32'h1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h59);
    chk("r59_00", 32'(count), 32'h00);
    chk("r59_wrap", 32'(wrap), 32'h1);

    // Directed table
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].clr, tbl[i].load, tbl[i].lv, tbl[i].en, tbl[i].up, tbl[i].lim);
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].exp_count));
      chk($sformatf("tbl%0d_wrap", i),  32'(wrap),  32'(tbl[i].exp_wrap));
      chk($sformatf("tbl%0d_tc", i),    32'(tc),    32'(tbl[i].exp_tc));
      chk($sformatf("tbl%0d_co", i),    32'(co),    32'(tbl[i].exp_tc & tbl[i].en));
    end

    // Random stimulus vs reference model
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0, 8'($urandom_range(0, 255)),
           $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : int2bcd($urandom_range(0, 99)));
      check_model("rnd");
    end

    // Cascade of two single-digit counters
    @(negedge clk);
    reset_c = 1'b0;
    en_c = 1'b1;
    for (int i = 1; i <= 99; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 37) chk("chain_37", 32'({count_hi, count_lo}), 32'h37);
    end
    chk("chain_99", 32'({count_hi, count_lo}), 32'h99);
    @(posedge clk);
    @(negedge clk);
    chk("chain_wrap_count", 32'({count_hi, count_lo}), 32'h00);
    chk("chain_wrap_hi", 32'(wrap_hi), 32'h1);
    for (int i = 1; i <= 37; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("chain_37b", 32'({count_hi, count_lo}), 32'h37);
    #2;
    reset_c = 1'b1;
    #1;
    chk("chain_async_count", 32'({count_hi, count_lo}), 32'h00);
    chk("chain_async_wrap", 32'({wrap_hi, wrap_lo}), 32'h0);
    @(negedge clk);
    reset_c = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("chain_resume", 32'({count_hi, count_lo}), 32'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
